// File: rtl/tpiu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpiu_pkg : sync patterns and lock FSM encoding shared by the sync tracker
// Revision : 1.0
// ---------------------------------------------------------------------------
package tpiu_pkg;

    localparam logic [31:0] TPIU_FULL_SYNC      = 32'h7FFF_FFFF;
    localparam logic [31:0] TPIU_HALF_SYNC_PAIR = 32'h7FFF_7FFF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } tpiu_state_e;

endpackage
`default_nettype wire

// File: rtl/tpiu_sync_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpiu_sync_match : finds full/half syncs at every 16-bit slot of the window
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tpiu_sync_match
    import tpiu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NSLOT  = DATA_W / 16,
    localparam int OFS_W  = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic [DATA_W+15:0] i_win,
    output logic               o_full_hit,
    output logic               o_half_hit,
    output logic [OFS_W-1:0]   o_slot
);

    logic [NSLOT-1:0] w_full_vec;
    logic [NSLOT-1:0] w_half_vec;
    logic [OFS_W-1:0] w_full_idx;
    logic [OFS_W-1:0] w_half_idx;

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        assign w_full_vec[k] = (i_win[16*k +: 32] == TPIU_FULL_SYNC);
        assign w_half_vec[k] = (i_win[16*k +: 32] == TPIU_HALF_SYNC_PAIR);
    end

    // Scan downwards so the lowest hitting slot is the one left standing
    always_comb begin
        w_full_idx = '0;
        w_half_idx = '0;
        for (int k = NSLOT - 1; k >= 0; k--) begin
            if (w_full_vec[k]) w_full_idx = OFS_W'(k);
            if (w_half_vec[k]) w_half_idx = OFS_W'(k);
        end
    end

    assign o_full_hit = |w_full_vec;
    assign o_half_hit = |w_half_vec;
    assign o_slot     = o_full_hit ? w_full_idx : w_half_idx;

endmodule
`default_nettype wire

// File: rtl/tpiu_sync_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpiu_sync_tracker : TPIU sync search, lock qualification and loss detection
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tpiu_sync_tracker
    import tpiu_pkg::*;
#(
    parameter  int DATA_W       = 32,
    parameter  int LOCK_CNT     = 2,
    parameter  int SYNC_TIMEOUT = 1024,
    localparam int NSLOT        = DATA_W / 16,
    localparam int OFS_W        = (NSLOT > 1) ? $clog2(NSLOT) : 1,
    localparam int TMR_W        = $clog2(SYNC_TIMEOUT + 1),
    localparam int CNT_W        = $clog2(LOCK_CNT + 1)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              sync_pulse_out,
    output logic              full_sync_out,
    output logic              half_sync_out,
    output logic [OFS_W-1:0]  sync_offset_out,
    output logic              locked_out,
    output logic              data_enable_out,
    output logic              lock_lost_out
);

    tpiu_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [OFS_W-1:0] r_ref, w_ref_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
    logic [15:0]      r_prev_hi;
    logic             w_lost;

    logic             w_full_hit, w_half_hit, w_match, w_expire;
    logic [OFS_W-1:0] w_slot;

    tpiu_sync_match #(.DATA_W(DATA_W)) u_match (
        .i_win      ({IN_DATA, r_prev_hi}),
        .o_full_hit (w_full_hit),
        .o_half_hit (w_half_hit),
        .o_slot     (w_slot)
    );

    assign w_match     = w_full_hit | w_half_hit;
    assign w_cnt_inc   = (r_cnt == CNT_W'(LOCK_CNT)) ? r_cnt : r_cnt + 1'b1;
    assign w_timer_inc = (r_timer == TMR_W'(SYNC_TIMEOUT)) ? r_timer : r_timer + 1'b1;
    // A match on the would-be expiring word keeps the state
    assign w_expire    = ~w_match && (w_timer_inc == TMR_W'(SYNC_TIMEOUT)) && (r_state != HUNT);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ref_nxt   = r_ref;
        w_timer_nxt = r_timer;
        w_lost      = 1'b0;
        if (IN_VALID) begin
            if (r_state == HUNT || w_match) w_timer_nxt = '0;
            else                            w_timer_nxt = w_timer_inc;
            case (r_state)
                HUNT: begin
                    if (w_full_hit) begin
                        w_ref_nxt   = w_slot;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_full_hit) begin
                        if (w_slot == r_ref) begin
                            w_cnt_nxt = w_cnt_inc;
                            if (w_cnt_inc == CNT_W'(LOCK_CNT)) w_state_nxt = LOCKED;
                        end else begin
                            w_ref_nxt = w_slot;
                            w_cnt_nxt = CNT_W'(1);
                        end
                    end else if (w_expire) begin
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = '0;
                        w_timer_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_full_hit && (w_slot != r_ref)) begin
                        w_state_nxt = VERIFY;
                        w_ref_nxt   = w_slot;
                        w_cnt_nxt   = CNT_W'(1);
                        w_lost      = 1'b1;
                    end else if (w_expire) begin
                        w_state_nxt = HUNT;
                        w_cnt_nxt   = '0;
                        w_timer_nxt = '0;
                        w_lost      = 1'b1;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state         <= HUNT;
            r_cnt           <= '0;
            r_ref           <= '0;
            r_timer         <= '0;
            r_prev_hi       <= '0;
            sync_pulse_out  <= 1'b0;
            full_sync_out   <= 1'b0;
            half_sync_out   <= 1'b0;
            sync_offset_out <= '0;
            locked_out      <= 1'b0;
            data_enable_out <= 1'b0;
            lock_lost_out   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_ref           <= w_ref_nxt;
            r_timer         <= w_timer_nxt;
            sync_pulse_out  <= IN_VALID & w_match;
            full_sync_out   <= IN_VALID & w_full_hit;
            half_sync_out   <= IN_VALID & ~w_full_hit & w_half_hit;
            data_enable_out <= IN_VALID & (r_state == LOCKED) & ~w_match;
            lock_lost_out   <= w_lost;
            locked_out      <= (w_state_nxt == LOCKED);
            if (IN_VALID) r_prev_hi <= IN_DATA[DATA_W-1 -: 16];
            if (IN_VALID && w_match) sync_offset_out <= w_slot;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tpiu_sync_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tpiu_sync_tracker : directed + random checks of two tracker configurations
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_tpiu_sync_tracker;

    localparam int A_W = 32, A_LOCK = 2, A_TMO = 4;
    localparam int B_W = 64, B_LOCK = 3, B_TMO = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   a_data = '0;
    logic          a_valid = 1'b0;
    logic [63:0]   b_data = '0;
    logic          b_valid = 1'b0;

    logic a_sync, a_full, a_half, a_locked, a_de, a_lost;
    logic b_sync, b_full, b_half, b_locked, b_de, b_lost;
    logic       a_ofs;
    logic [1:0] b_ofs;

    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;

    // Reference model state, index 0 = 32-bit unit, 1 = 64-bit unit
    int          m_st[2], m_cnt[2], m_ref[2], m_tmr[2];
    logic [15:0] m_prev[2];
    logic [1:0]  m_ofs[2];
    bit          e_sync[2], e_full[2], e_half[2], e_locked[2], e_de[2], e_lost[2];

    always #5 clk = ~clk;

    tpiu_sync_tracker #(.DATA_W(A_W), .LOCK_CNT(A_LOCK), .SYNC_TIMEOUT(A_TMO)) u_dut_a (
        .ACLK            (clk),
        .ARESET          (rst),
        .IN_DATA         (a_data),
        .IN_VALID        (a_valid),
        .sync_pulse_out  (a_sync),
        .full_sync_out   (a_full),
        .half_sync_out   (a_half),
        .sync_offset_out (a_ofs),
        .locked_out      (a_locked),
        .data_enable_out (a_de),
        .lock_lost_out   (a_lost)
    );

    tpiu_sync_tracker #(.DATA_W(B_W), .LOCK_CNT(B_LOCK), .SYNC_TIMEOUT(B_TMO)) u_dut_b (
        .ACLK            (clk),
        .ARESET          (rst),
        .IN_DATA         (b_data),
        .IN_VALID        (b_valid),
        .sync_pulse_out  (b_sync),
        .full_sync_out   (b_full),
        .half_sync_out   (b_half),
        .sync_offset_out (b_ofs),
        .locked_out      (b_locked),
        .data_enable_out (b_de),
        .lock_lost_out   (b_lost)
    );

    task automatic t_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", tag, n_cycle, got, exp);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_st[u] = 0; m_cnt[u] = 0; m_ref[u] = 0; m_tmr[u] = 0;
            m_prev[u] = '0; m_ofs[u] = '0;
            e_sync[u] = 0; e_full[u] = 0; e_half[u] = 0;
            e_locked[u] = 0; e_de[u] = 0; e_lost[u] = 0;
        end
    endtask

    // States: 0 hunt, 1 verify, 2 locked
    task automatic model_step(input int u, input logic [63:0] d, input bit v);
        int          dw, lock, tmo, full_k, half_k;
        bit          matched;
        logic [79:0] win;
        dw   = (u == 0) ? A_W : B_W;
        lock = (u == 0) ? A_LOCK : B_LOCK;
        tmo  = (u == 0) ? A_TMO : B_TMO;
        e_sync[u] = 0; e_full[u] = 0; e_half[u] = 0; e_de[u] = 0; e_lost[u] = 0;
        if (!v) return;
        win    = ({16'h0, d} << 16) | {64'h0, m_prev[u]};
        full_k = -1;
        half_k = -1;
        for (int k = 0; k < dw / 16; k++) begin
            if (win[16*k +: 32] == 32'h7FFF_FFFF && full_k < 0) full_k = k;
            if (win[16*k +: 32] == 32'h7FFF_7FFF && half_k < 0) half_k = k;
        end
        matched  = (full_k >= 0) || (half_k >= 0);
        e_de[u]  = (m_st[u] == 2) && !matched;
        if (full_k >= 0) begin
            e_full[u] = 1; e_sync[u] = 1; m_ofs[u] = 2'(full_k);
        end else if (half_k >= 0) begin
            e_half[u] = 1; e_sync[u] = 1; m_ofs[u] = 2'(half_k);
        end
        if (m_st[u] == 0 || matched) m_tmr[u] = 0;
        else if (m_tmr[u] < tmo)     m_tmr[u]++;
        if (m_st[u] == 0) begin
            if (full_k >= 0) begin
                m_ref[u] = full_k; m_cnt[u] = 1;
                m_st[u]  = (lock == 1) ? 2 : 1;
            end
        end else if (full_k >= 0 && full_k != m_ref[u]) begin
            if (m_st[u] == 2) e_lost[u] = 1;
            m_st[u] = 1; m_ref[u] = full_k; m_cnt[u] = 1;
        end else if (full_k >= 0) begin
            m_cnt[u]++;
            if (m_st[u] == 1 && m_cnt[u] >= lock) m_st[u] = 2;
        end else if (!matched && m_tmr[u] == tmo) begin
            if (m_st[u] == 2) e_lost[u] = 1;
            m_st[u] = 0; m_cnt[u] = 0; m_tmr[u] = 0;
        end
        e_locked[u] = (m_st[u] == 2);
        m_prev[u]   = d[dw-16 +: 16];
    endtask

    function automatic logic [63:0] dut_outs(input int u);
        if (u == 0) return {56'h0, a_sync, a_full, a_half, a_locked, a_de, a_lost, 1'b0, a_ofs};
        return {56'h0, b_sync, b_full, b_half, b_locked, b_de, b_lost, b_ofs};
    endfunction

    function automatic logic [63:0] model_outs(input int u);
        return {56'h0, e_sync[u], e_full[u], e_half[u], e_locked[u], e_de[u], e_lost[u], m_ofs[u]};
    endfunction

    task automatic cycle(input logic [31:0] da, input bit va, input logic [63:0] db, input bit vb);
        @(negedge clk);
        a_data = da; a_valid = va; b_data = db; b_valid = vb;
        model_step(0, {32'h0, da}, va);
        model_step(1, db, vb);
        @(posedge clk);
        #1;
        n_cycle++;
        t_check("unitA_outs", dut_outs(0), model_outs(0));
        t_check("unitB_outs", dut_outs(1), model_outs(1));
    endtask

    task automatic feed_a(input logic [31:0] d);
        cycle(d, 1'b1, 64'h0, 1'b0);
    endtask

    task automatic feed_b(input logic [63:0] d);
        cycle(32'h0, 1'b0, d, 1'b1);
    endtask

    function automatic logic [15:0] rand_half();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 30) return 32'h7FFF_FFFF;
        if (r < 40) return 32'h7FFF_7FFF;
        if (r < 75) return {rand_half(), rand_half()};
        return $urandom;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        t_check("reset_A", dut_outs(0), 64'h0);
        t_check("reset_B", dut_outs(1), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Aligned full syncs lock unit A at slot 1
        feed_a(32'h7FFF_FFFF);
        t_check("t1_full0", {63'h0, a_full}, 64'h1);
        feed_a(32'h1234_5678);
        t_check("t1_no_de", {63'h0, a_de}, 64'h0);
        feed_a(32'h7FFF_FFFF);
        t_check("t1_locked", {62'h0, a_locked, a_ofs}, 64'h3);

        // Half pair while locked: strobes only, lock kept
        feed_a(32'h7FFF_7FFF);
        t_check("t3_half", {60'h0, a_sync, a_full, a_half, a_locked}, 64'hB);

        // Timeout after four quiet words
        for (int i = 0; i < 4; i++) feed_a(32'h1111_1111);
        t_check("t4_timeout", {62'h0, a_locked, a_lost}, 64'h1);
        feed_a(32'h7FFF_FFFF);
        feed_a(32'h7FFF_FFFF);
        for (int i = 0; i < 3; i++) feed_a(32'h2222_2222);
        feed_a(32'h7FFF_FFFF);
        t_check("t4_retain", {62'h0, a_locked, a_lost}, 64'h2);

        // Straddled full sync at slot 0 breaks the slot-1 lock
        feed_a(32'hFFFF_0000);
        feed_a(32'h0000_7FFF);
        t_check("t5_relock", {61'h0, a_locked, a_lost, a_ofs}, 64'h2);

        // 64-bit straddle, back-to-back then across an idle gap
        feed_b(64'hFFFF_0000_0000_0000);
        feed_b(64'h0000_0000_0000_7FFF);
        t_check("t2_straddle", {61'h0, b_full, b_ofs}, 64'h4);
        feed_b(64'hFFFF_0000_0000_0000);
        cycle(32'h0, 1'b0, 64'h0, 1'b0);
        feed_b(64'h0000_0000_0000_7FFF);
        t_check("t2_gap", {61'h0, b_full, b_ofs}, 64'h4);

        // Asynchronous reset between edges while unit A verifies
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        t_check("t6_async_A", dut_outs(0), 64'h0);
        t_check("t6_async_B", dut_outs(1), 64'h0);
        #1 rst = 1'b0;
        feed_a(32'h7FFF_FFFF);
        t_check("t6_not_locked", {63'h0, a_locked}, 64'h0);
        feed_a(32'h7FFF_FFFF);
        t_check("t6_locked", {63'h0, a_locked}, 64'h1);

        // Randomized traffic on both units against the model
        for (int i = 0; i < 1500; i++) begin
            cycle(rand_word(), ($urandom_range(0, 4) != 0),
                  {rand_word(), rand_word()}, ($urandom_range(0, 4) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tpiu_sync_tracker.md
Name: tpiu_sync_tracker

Overview:
- Parametrised successor to the single-word TPIU sync detector.
- Searches a DATA_W-bit trace stream for full syncs (32'h7FFFFFFF) and half-sync pairs (32'h7FFF7FFF) at any 16-bit-aligned offset, including matches that straddle two words.
- Runs a lock FSM that qualifies sync alignment and detects loss of sync.
- Sits between the trace capture front-end and the TPIU frame deformatter; provides the alignment offset and data-enable strobes the deformatter consumes.

Parameters:
- DATA_W, 32, input word width; multiple of 16, minimum 32.
- LOCK_CNT, 2, consecutive full syncs at the same offset required to declare lock; minimum 1.
- SYNC_TIMEOUT, 1024, valid words allowed without any sync before lock is dropped; minimum 2.
- Derived localparams: NSLOT = DATA_W/16; OFS_W = max(1, clog2(NSLOT)); TMR_W = clog2(SYNC_TIMEOUT+1).

Ports:
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  asynchronous reset, active-high.
- IN_DATA  in  DATA_W  trace word.
- IN_VALID  in  1  qualifies IN_DATA.
- sync_pulse_out  out  1  one-cycle strobe: full or half sync found in the accepted word.
- full_sync_out  out  1  one-cycle strobe: full sync found.
- half_sync_out  out  1  one-cycle strobe: half pair found, no full sync.
- sync_offset_out  out  OFS_W  slot index k of the reported match; held between matches.
- locked_out  out  1  level: FSM in LOCKED.
- data_enable_out  out  1  strobe: LOCKED, word accepted, and no sync in that word.
- lock_lost_out  out  1  one-cycle strobe on the LOCKED -> non-LOCKED transition.

Behaviour:
- **Reset.** ARESET asserts asynchronously. All outputs go to 0, the FSM goes to HUNT, prev_hi (16 bits) clears to 0, and the counter and timer clear to 0.
- **Search window.** W = {IN_DATA, prev_hi}, DATA_W+16 bits wide.
  - Slot k (0..NSLOT-1) is W[16k+31 : 16k].
  - Slot 0 straddles the previous word's upper half and the current word's lower half.
  - prev_hi <= IN_DATA[DATA_W-1 : DATA_W-16] on each accepted word only.
- **Acceptance.** A word is accepted on a cycle with IN_VALID=1. With IN_VALID=0 there is no detection; prev_hi, the timer and the FSM all hold, and every strobe is 0.
- **Match priority.**
  - Any slot equal to FULL -> full match; the lowest such k is reported.
  - Otherwise, any slot equal to HALF_PAIR -> half match; the lowest such k is reported.
- **Latency.** All outputs are registered. Strobes assert exactly 1 cycle after the accepting edge; locked_out changes on the same edge.
- **FSM states:** HUNT, VERIFY, LOCKED. Internal registers: cnt, ref_ofs, timer.
  - HUNT:
    - full match -> ref_ofs = k, cnt = 1.
    - Next state is LOCKED if LOCK_CNT == 1, else VERIFY.
  - VERIFY:
    - full match with k == ref_ofs -> cnt++; at cnt == LOCK_CNT -> LOCKED.
    - full match with k != ref_ofs -> ref_ofs = k, cnt = 1, stay in VERIFY.
  - LOCKED:
    - full match with k != ref_ofs -> VERIFY, ref_ofs = k, cnt = 1, lock_lost strobe.
    - A half match never changes state.
  - Timeout (VERIFY or LOCKED):
    - timer counts accepted words with no full or half match and saturates at SYNC_TIMEOUT.
    - timer clears on any match.
    - When timer reaches SYNC_TIMEOUT -> HUNT, cnt = 0; lock_lost strobe if leaving LOCKED.
- **Simultaneous events.** A match on the word that would expire the timer wins: the timer clears and the state is kept.
- **Held outputs.** sync_offset_out updates on every full or half match, in any state.
- **Reset mid-stream.** State is discarded. After release, prev_hi = 0, so slot 0 of the first word cannot hit an all-ones pattern spanning the reset.
- **Compatibility.** With DATA_W = 32 and a word-aligned stream, sync_pulse_out matches the legacy enable for slot 1.

Decomposition:
- Shared package tpiu_pkg holds:
  - TPIU_FULL_SYNC = 32'h7FFFFFFF
  - TPIU_HALF_SYNC_PAIR = 32'h7FFF7FFF
  - the FSM state encoding (HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2)
- One sub-module: tpiu_sync_match. It is purely combinational and is parametrised by DATA_W. It takes W and returns full_hit, half_hit and lowest-slot index. The FSM, timer and output registers stay in the top level.

Test Plan:
1. DATA_W=32, LOCK_CNT=2. Words 0x7FFFFFFF, 0x12345678, 0x7FFFFFFF with IN_VALID=1.
   - full_sync_out pulses on cycles 1 and 3 with offset 1.
   - locked_out rises on the edge after the third word.
   - data_enable_out pulses for word 0x12345678 only if locked at that point; it must not pulse here.
2. DATA_W=64, straddled sync: word A = 0xFFFF_0000_0000_0000, then word B = 0x0000_0000_0000_7FFF.
   - full_sync_out = 1 with sync_offset_out = 0 one cycle after B.
   - Same sequence separated by an IN_VALID=0 gap: still matches, since prev_hi holds.
3. DATA_W=32, word 0x7FFF7FFF with no full sync.
   - half_sync_out = 1, full_sync_out = 0, sync_pulse_out = 1, FSM state unchanged.
4. Locked, SYNC_TIMEOUT=4: feed 4 non-sync valid words.
   - locked_out falls and lock_lost_out pulses once after the 4th word.
   - Repeat with a full sync as the 4th word: lock retained.
5. Locked at offset 1: full sync arrives at offset 0 via a straddle.
   - FSM goes to VERIFY, lock_lost_out pulses, sync_offset_out = 0.
6. ARESET pulsed asynchronously mid-VERIFY, between clock edges.
   - All outputs 0 immediately.
   - The first post-reset word 0x7FFFFFFF still requires LOCK_CNT full syncs to lock.
